// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (imem) and memory-stage (dmem) requesters.
// Request pulses are latched into per-port slots; dmem wins unless fetch has waited MAX_D_STREAK grants.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e        state_q, state_d;

  logic          pi_vld_q, pi_vld_d;
  logic [31:0]   pi_addr_q, pi_addr_d;
  logic [3:0]    pi_rmask_q, pi_rmask_d;

  logic          pd_vld_q, pd_vld_d;
  logic [31:0]   pd_addr_q, pd_addr_d;
  logic [3:0]    pd_rmask_q, pd_rmask_d;
  logic [3:0]    pd_wmask_q, pd_wmask_d;
  logic [31:0]   pd_wdata_q, pd_wdata_d;

  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;

  logic [31:0]   maddr_q, maddr_d;
  logic [3:0]    mrmask_q, mrmask_d;
  logic [3:0]    mwmask_q, mwmask_d;
  logic [31:0]   mwdata_q, mwdata_d;

  function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] v);
    if (v >= STREAK_MAX) return STREAK_MAX;
    return v + SW'(1);
  endfunction

  logic        i_pulse, d_pulse;
  logic        i_owned, d_owned;
  logic        i_cap, d_cap;
  logic        i_viol, d_viol;
  logic        idle_resp;
  logic        arb_en;
  logic        i_cand, d_cand;
  logic        grant_i, grant_d;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  i_rmask, d_rmask, d_wmask;

  assign i_pulse = |imem_rmask;
  assign d_pulse = |(dmem_rmask | dmem_wmask);

  // A port's in-flight transaction retires in the cycle its mem_resp arrives,
  // so a pulse in that same cycle is a legal new request.
  assign i_owned = pi_vld_q | ((state_q == BUSY_I) & ~mem_resp);
  assign d_owned = pd_vld_q | ((state_q == BUSY_D) & ~mem_resp);

  assign i_cap  = i_pulse & ~i_owned;
  assign d_cap  = d_pulse & ~d_owned;
  assign i_viol = i_pulse & i_owned;
  assign d_viol = d_pulse & d_owned;

  assign idle_resp = mem_resp & (state_q == IDLE);
  assign arb_en    = (state_q == IDLE) | mem_resp;

  assign i_cand = pi_vld_q | i_cap;
  assign d_cand = pd_vld_q | d_cap;

  assign i_addr  = pi_vld_q ? pi_addr_q  : imem_addr;
  assign i_rmask = pi_vld_q ? pi_rmask_q : imem_rmask;
  assign d_addr  = pd_vld_q ? pd_addr_q  : dmem_addr;
  assign d_rmask = pd_vld_q ? pd_rmask_q : dmem_rmask;
  assign d_wmask = pd_vld_q ? pd_wmask_q : dmem_wmask;
  assign d_wdata = pd_vld_q ? pd_wdata_q : dmem_wdata;

  assign grant_d = arb_en & d_cand & ~(i_cand & (streak_q == STREAK_MAX));
  assign grant_i = arb_en & i_cand & ~grant_d;

  always_comb begin
    state_d    = state_q;
    pi_vld_d   = pi_vld_q;
    pi_addr_d  = pi_addr_q;
    pi_rmask_d = pi_rmask_q;
    pd_vld_d   = pd_vld_q;
    pd_addr_d  = pd_addr_q;
    pd_rmask_d = pd_rmask_q;
    pd_wmask_d = pd_wmask_q;
    pd_wdata_d = pd_wdata_q;
    streak_d   = streak_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    mrmask_d   = '0;
    mwmask_d   = '0;
    err_d      = err_q | i_viol | d_viol | idle_resp;

    if (i_cap) begin
      pi_vld_d   = 1'b1;
      pi_addr_d  = imem_addr;
      pi_rmask_d = imem_rmask;
    end
    if (d_cap) begin
      pd_vld_d   = 1'b1;
      pd_addr_d  = dmem_addr;
      pd_rmask_d = dmem_rmask;
      pd_wmask_d = dmem_wmask;
      pd_wdata_d = dmem_wdata;
    end

    if (arb_en) begin
      state_d = IDLE;
      if (grant_d) begin
        state_d  = BUSY_D;
        pd_vld_d = 1'b0;
        maddr_d  = d_addr;
        mrmask_d = d_rmask;
        mwmask_d = d_wmask;
        mwdata_d = d_wdata;
        streak_d = i_cand ? streak_sat_inc(streak_q) : '0;
      end else if (grant_i) begin
        state_d  = BUSY_I;
        pi_vld_d = 1'b0;
        maddr_d  = i_addr;
        mrmask_d = i_rmask;
        mwmask_d = '0;
        mwdata_d = '0;
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pi_vld_q   <= 1'b0;
      pi_addr_q  <= '0;
      pi_rmask_q <= '0;
      pd_vld_q   <= 1'b0;
      pd_addr_q  <= '0;
      pd_rmask_q <= '0;
      pd_wmask_q <= '0;
      pd_wdata_q <= '0;
      streak_q   <= '0;
      err_q      <= 1'b0;
      maddr_q    <= '0;
      mrmask_q   <= '0;
      mwmask_q   <= '0;
      mwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      pi_vld_q   <= pi_vld_d;
      pi_addr_q  <= pi_addr_d;
      pi_rmask_q <= pi_rmask_d;
      pd_vld_q   <= pd_vld_d;
      pd_addr_q  <= pd_addr_d;
      pd_rmask_q <= pd_rmask_d;
      pd_wmask_q <= pd_wmask_d;
      pd_wdata_q <= pd_wdata_d;
      streak_q   <= streak_d;
      err_q      <= err_d;
      maddr_q    <= maddr_d;
      mrmask_q   <= mrmask_d;
      mwmask_q   <= mwmask_d;
      mwdata_q   <= mwdata_d;
    end
  end

  assign mem_addr   = maddr_q;
  assign mem_rmask  = mrmask_q;
  assign mem_wmask  = mwmask_q;
  assign mem_wdata  = mwdata_q;
  assign err        = err_q;

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign imem_resp  = mem_resp & (state_q == BUSY_I);
  assign dmem_resp  = mem_resp & (state_q == BUSY_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus scripted sequences, with a
// scoreboard of expected memory issues and per-port responses.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic        err;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
  } rsp_t;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  iss_t exp_iss[$];
  rsp_t exp_ir[$];
  rsp_t exp_dr[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    imem_rmask = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
  endtask

  task automatic push_iss(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] wd);
    exp_iss.push_back('{addr: a, rmask: rm, wmask: wm, wdata: wd});
  endtask

  task automatic req_i(input logic [31:0] a, input logic [3:0] rm, input logic [31:0] rd);
    imem_addr  = a;
    imem_rmask = rm;
    exp_ir.push_back('{rdata: rd, chk: 1'b1});
  endtask

  task automatic req_d(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input logic [31:0] rd);
    dmem_addr  = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    exp_dr.push_back('{rdata: rd, chk: (wm == 4'd0)});
  endtask

  task automatic monitor();
    iss_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_rmask != 4'd0 || mem_wmask != 4'd0) begin
          if (exp_iss.size() == 0) begin
            n_total++;
            $display("FAIL iss_unexpected: got addr 0x%08h rmask %h wmask %h, required no issue",
                     mem_addr, mem_rmask, mem_wmask);
          end else begin
            e = exp_iss.pop_front();
            chk("iss_addr", mem_addr, e.addr);
            chk("iss_rmask", 32'(mem_rmask), 32'(e.rmask));
            chk("iss_wmask", 32'(mem_wmask), 32'(e.wmask));
            if (e.wmask != 4'd0) chk("iss_wdata", mem_wdata, e.wdata);
          end
        end
        if (imem_resp) begin
          if (exp_ir.size() == 0) begin
            n_total++;
            $display("FAIL imem_resp_unexpected: got imem_resp=1, required 0");
          end else begin
            r = exp_ir.pop_front();
            chk("imem_rdata", imem_rdata, r.rdata);
          end
        end
        if (dmem_resp) begin
          if (exp_dr.size() == 0) begin
            n_total++;
            $display("FAIL dmem_resp_unexpected: got dmem_resp=1, required 0");
          end else begin
            r = exp_dr.pop_front();
            if (r.chk) chk("dmem_rdata", dmem_rdata, r.rdata);
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] st_rd(input int idx);
    return 32'h5000_0000 + 32'(idx);
  endfunction

  function automatic logic [31:0] st_addr(input int idx);
    if (idx == 4) return 32'h6000_0300;
    if (idx == 5) return 32'h1000_0310;
    return 32'h1000_0300 + 32'(idx * 4);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    vec_t v;

    vt[0] = '{1'b0, 32'h6000_0000, 4'hF, 4'h0, 32'h0,         32'h0000_0013, 2};
    vt[1] = '{1'b1, 32'h1000_0004, 4'hF, 4'h0, 32'h0,         32'hCAFE_BABE, 0};
    vt[2] = '{1'b1, 32'h1000_0008, 4'h0, 4'h3, 32'h0000_ABCD, 32'h0,         1};
    vt[3] = '{1'b1, 32'h1000_0011, 4'h1, 4'h0, 32'h0,         32'h0000_00AA, 3};
    vt[4] = '{1'b0, 32'h6000_0004, 4'hF, 4'h0, 32'h0,         32'h0050_0093, 1};

    fork
      monitor();
    join_none

    // Reset state
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst_mem_rmask", 32'(mem_rmask), 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_imem_resp", 32'(imem_resp), 32'h0);
    chk("rst_dmem_resp", 32'(dmem_resp), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_imem_rdata", imem_rdata, 32'h1234_5678);
    chk("rst_dmem_rdata", dmem_rdata, 32'h1234_5678);
    tick();
    rst = 1'b1;
    tick();

    // Vector table: single transactions with varying response latency
    for (int i = 0; i < 5; i++) begin
      v = vt[i];
      push_iss(v.addr, v.rmask, v.wmask, v.wdata);
      if (v.is_d) req_d(v.addr, v.rmask, v.wmask, v.wdata, v.rdata);
      else        req_i(v.addr, v.rmask, v.rdata);
      tick();
      clear_req();
      for (int k = 0; k <= v.lat; k++) begin
        if (k == v.lat) begin
          mem_resp  = 1'b1;
          mem_rdata = v.rdata;
        end
        @(negedge clk);
        if (k == 0) begin
          chk($sformatf("v%0d_issue_rmask", i), 32'(mem_rmask), 32'(v.rmask));
          chk($sformatf("v%0d_issue_wmask", i), 32'(mem_wmask), 32'(v.wmask));
        end
        if (k == 1) chk($sformatf("v%0d_mask_one_cycle", i), 32'({mem_rmask, mem_wmask}), 32'h0);
        if (k == v.lat)
          chk($sformatf("v%0d_resp", i), 32'(v.is_d ? dmem_resp : imem_resp), 32'h1);
        tick();
      end
      mem_resp  = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", i), 32'({mem_rmask, mem_wmask}), 32'h0);
      tick();
    end

    // Simultaneous requests: dmem store first, then fetch
    push_iss(32'h1000_0100, 4'h0, 4'h3, 32'h0000_ABCD);
    push_iss(32'h6000_0100, 4'hF, 4'h0, 32'h0);
    req_i(32'h6000_0100, 4'hF, 32'h0000_0517);
    req_d(32'h1000_0100, 4'h0, 4'h3, 32'h0000_ABCD, 32'h0);
    tick();
    clear_req();
    @(negedge clk);
    chk("sim_first_is_d_wmask", 32'(mem_wmask), 32'h3);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("sim_dresp", 32'(dmem_resp), 32'h1);
    chk("sim_no_iresp_yet", 32'(imem_resp), 32'h0);
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("sim_second_rmask", 32'(mem_rmask), 32'hF);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h0000_0517;
    @(negedge clk);
    chk("sim_iresp", 32'(imem_resp), 32'h1);
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("sim_idle_after", 32'({mem_rmask, mem_wmask}), 32'h0);
    tick();

    // Back-to-back dmem: re-pulse in the resp cycle, next issue without a bubble
    push_iss(32'h1000_0200, 4'hF, 4'h0, 32'h0);
    push_iss(32'h1000_0204, 4'hF, 4'h0, 32'h0);
    req_d(32'h1000_0200, 4'hF, 4'h0, 32'h0, 32'h1111_1111);
    tick();
    clear_req();
    mem_resp  = 1'b1;
    mem_rdata = 32'h1111_1111;
    req_d(32'h1000_0204, 4'hF, 4'h0, 32'h0, 32'h2222_2222);
    @(negedge clk);
    chk("b2b_first_resp", 32'(dmem_resp), 32'h1);
    tick();
    clear_req();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("b2b_next_rmask", 32'(mem_rmask), 32'hF);
    chk("b2b_next_addr", mem_addr, 32'h1000_0204);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h2222_2222;
    @(negedge clk);
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("b2b_idle_after", 32'({mem_rmask, mem_wmask}), 32'h0);
    tick();

    // Starvation guard: 4 dmem grants, then the waiting fetch, then the queued dmem
    for (int j = 0; j < 6; j++) push_iss(st_addr(j), 4'hF, 4'h0, 32'h0);
    req_i(st_addr(4), 4'hF, st_rd(4));
    req_d(st_addr(0), 4'hF, 4'h0, 32'h0, st_rd(0));
    tick();
    clear_req();
    for (int j = 0; j < 6; j++) begin
      mem_resp  = 1'b1;
      mem_rdata = st_rd(j);
      if (j < 4) req_d(st_addr(j + 1 < 4 ? j + 1 : 5), 4'hF, 4'h0, 32'h0,
                       st_rd(j + 1 < 4 ? j + 1 : 5));
      @(negedge clk);
      if (j == 4) begin
        chk("starve_i_grant_addr", mem_addr, 32'h6000_0300);
        chk("starve_i_resp", 32'(imem_resp), 32'h1);
      end else begin
        chk($sformatf("starve_d%0d_resp", j), 32'(dmem_resp), 32'h1);
      end
      tick();
      clear_req();
      mem_resp = 1'b0;
    end
    @(negedge clk);
    chk("starve_idle_after", 32'({mem_rmask, mem_wmask}), 32'h0);
    chk("no_err_so_far", 32'(err), 32'h0);
    tick();

    // Violation: second fetch pulse while fetch in flight
    push_iss(32'h6000_0500, 4'hF, 4'h0, 32'h0);
    req_i(32'h6000_0500, 4'hF, 32'h0000_0A0A);
    tick();
    clear_req();
    imem_addr  = 32'h6000_0504;
    imem_rmask = 4'hF;
    tick();
    clear_req();
    @(negedge clk);
    chk("viol_err", 32'(err), 32'h1);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h0000_0A0A;
    @(negedge clk);
    chk("viol_one_resp", 32'(imem_resp), 32'h1);
    tick();
    mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("viol_no_reissue%0d", k), 32'({mem_rmask, imem_resp}), 32'h0);
      tick();
    end

    // mem_resp while idle
    rst = 1'b0;
    #1;
    chk("rst2_err_clear", 32'(err), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h3333_3333;
    @(negedge clk);
    chk("idle_resp_no_iresp", 32'(imem_resp), 32'h0);
    chk("idle_resp_no_dresp", 32'(dmem_resp), 32'h0);
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("idle_resp_err", 32'(err), 32'h1);
    tick();

    // Async reset while BUSY_D, then a late response
    push_iss(32'h1000_0400, 4'h0, 4'hF, 32'h5555_AAAA);
    dmem_addr  = 32'h1000_0400;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'h5555_AAAA;
    tick();
    clear_req();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_wmask", 32'(mem_wmask), 32'h0);
    chk("async_rst_addr", mem_addr, 32'h0);
    chk("async_rst_wdata", mem_wdata, 32'h0);
    chk("async_rst_err", 32'(err), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h4444_4444;
    @(negedge clk);
    chk("late_resp_no_dresp", 32'(dmem_resp), 32'h0);
    chk("late_resp_no_iresp", 32'(imem_resp), 32'h0);
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    chk("late_resp_err", 32'(err), 32'h1);
    tick();

    chk("sb_iss_drained", 32'(exp_iss.size()), 32'h0);
    chk("sb_ir_drained", 32'(exp_ir.size()), 32'h0);
    chk("sb_dr_drained", 32'(exp_dr.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the fetch-side (imem) and memory-stage (dmem) requesters of the rv32i pipeline.
- Latches single-cycle request pulses and grants one transaction at a time.
- Routes the memory response back to the owning requester.
- dmem has priority, with a bounded-streak guard so fetch is never starved.

Parameters:
MAX_D_STREAK, 4, max consecutive dmem grants while an imem request waits; range 1..15.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
imem_addr  in  32  fetch address, sampled when imem_rmask != 0
imem_rmask  in  4  fetch read mask; nonzero for one cycle = request pulse
imem_rdata  out  32  fetch read data, valid with imem_resp
imem_resp  out  1  fetch completion pulse
dmem_addr  in  32  data address
dmem_rmask  in  4  data read mask
dmem_wmask  in  4  data write mask; request pulse = (rmask|wmask) != 0 for one cycle
dmem_wdata  in  32  store data
dmem_rdata  out  32  load data, valid with dmem_resp
dmem_resp  out  1  data completion pulse (reads and writes)
mem_addr  out  32  shared port address, registered
mem_rmask  out  4  shared port read mask, registered, nonzero one cycle per issue
mem_wmask  out  4  shared port write mask, registered, nonzero one cycle per issue
mem_wdata  out  32  shared port write data, registered
mem_rdata  in  32  memory read data, valid with mem_resp
mem_resp  in  1  memory completion pulse
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pending_i=pending_d=0; d_streak=0; err=0.
  - All mem_* outputs 0. imem_resp=dmem_resp=0. imem_rdata/dmem_rdata follow mem_rdata.
  - Reset mid-transaction abandons it. A later mem_resp seen in IDLE is dropped and sets err.
- Capture: a request pulse on a port with no pending or in-flight request of its own is latched into that port's pending slot: addr, masks, wdata.
- Violation: a pulse while that port already has a pending or in-flight request is dropped and sets err.
- States: IDLE, BUSY_I, BUSY_D.
- Arbitration: evaluated at a clock edge when state=IDLE, or when state=BUSY_x and mem_resp=1. Candidates are pending slots plus any pulse arriving this cycle.
  - dmem wins, unless an imem candidate exists and d_streak==MAX_D_STREAK; then imem wins.
  - The winner's fields are registered onto mem_*, masks driven for exactly the next cycle. The winner's pending slot clears. State -> BUSY_I or BUSY_D.
  - No candidate: state -> IDLE, mem masks 0.
- Streak counter:
  - d_streak increments (saturating at MAX_D_STREAK) on a dmem grant while an imem candidate exists.
  - It resets to 0 on an imem grant, or on a dmem grant with no imem candidate.
- Latency:
  - Request pulse in cycle N with arbiter idle -> mem request visible in cycle N+1.
  - mem_resp in cycle M -> x_resp=1 combinationally in cycle M, with x_rdata=mem_rdata.
  - The next queued grant is visible on mem_* in cycle M+1 (back-to-back, no bubble).
- Response routing:
  - imem_resp = mem_resp & (state==BUSY_I); dmem_resp = mem_resp & (state==BUSY_D).
  - mem_resp in IDLE sets err and produces no resp.
- Simultaneous events:
  - A request pulse in the same cycle as mem_resp for that port's in-flight transaction is legal. It is captured and eligible in that cycle's arbitration.
  - Pulses on both ports in the same cycle are both captured.
- Write transactions: dmem_rdata is don't-care; dmem_resp is still pulsed.
- err clears only on reset.

Test Plan:
- Single fetch: imem pulse addr=0x6000_0000 rmask=0xF at cycle 1; mem_resp at cycle 4 with rdata=0x0000_0013 -> mem_rmask=0xF only in cycle 2; imem_resp=1 and imem_rdata=0x13 in cycle 4; state IDLE after.
- Simultaneous requests: imem and dmem (store, wmask=0x3, wdata=0xABCD) pulse in the same cycle -> dmem issued first. On its mem_resp, imem is issued the next cycle. dmem_resp then imem_resp, each exactly once.
- Starvation guard, MAX_D_STREAK=4: imem pending while dmem re-requests on every resp -> 4 dmem grants, then the imem grant, then d_streak=0.
- Back-to-back dmem: dmem re-pulses in the same cycle as its mem_resp -> new mem request in the very next cycle, no idle cycle.
- Violations: second imem pulse while imem is in flight -> err=1 and only one imem_resp. Separately, mem_resp in IDLE -> err=1 with no resp output.
- Async reset mid-transaction: rst=0 while BUSY_D -> all outputs 0 immediately without waiting for a clock edge; err=0. A late mem_resp after release -> dropped, err=1.
